// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder: queues AR requests in order, waits a
// programmable latency per burst, then returns INCR beats whose data is the
// beat address (or zero with SLVERR when the address falls outside bar..limit).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no active burst; pops the FIFO head when one is queued
// ST_WAIT  | latency countdown for the active burst
// ST_BURST | presenting beats on R, one per accepted handshake
module axi_read_responder #(
    parameter int ADDR_BITS       = 64,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 64,
    parameter int LOG_FIFO_DEPTH  = 2,
    parameter int LATENCY_WIDTH   = 8
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        s_ar_valid,
    output logic                        s_ar_ready,
    input  logic [ADDR_BITS-1:0]        s_ar_addr,
    input  logic [BURST_LEN_WIDTH-1:0]  s_ar_len,
    input  logic [TID_WIDTH-1:0]        s_ar_id,
    output logic                        s_r_valid,
    input  logic                        s_r_ready,
    output logic [TID_WIDTH-1:0]        s_r_id,
    output logic [DATA_WIDTH-1:0]       s_r_data,
    output logic [1:0]                  s_r_resp,
    output logic                        s_r_last,
    input  logic [ADDR_BITS-1:0]        bar,
    input  logic [ADDR_BITS-1:0]        limit,
    input  logic [LATENCY_WIDTH-1:0]    latency,
    output logic [LOG_FIFO_DEPTH+1:0]   outstandingCnt
);

    localparam int DEPTH      = 1 << LOG_FIFO_DEPTH;
    localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BURST} state_t;

    state_t state, state_nxt;

    logic [ADDR_BITS-1:0]       fifo_addr [DEPTH];
    logic [BURST_LEN_WIDTH-1:0] fifo_len  [DEPTH];
    logic [TID_WIDTH-1:0]       fifo_id   [DEPTH];
    logic [LOG_FIFO_DEPTH-1:0]  wr_ptr, rd_ptr;
    logic [LOG_FIFO_DEPTH:0]    fifo_cnt;
    logic                       out_of_reset;
    logic                       fifo_full, fifo_empty, push, pop;

    logic [ADDR_BITS-1:0]       act_addr;
    logic [BURST_LEN_WIDTH-1:0] act_len;
    logic [TID_WIDTH-1:0]       act_id;
    logic [BURST_LEN_WIDTH-1:0] beat_cnt;
    logic [LATENCY_WIDTH-1:0]   wait_cnt;
    logic [ADDR_BITS-1:0]       beat_addr;
    logic                       beat_in_range;
    logic                       beat_is_last;

    // Ready comes only from registered state, so a same-cycle pop never
    // unblocks a push into a full FIFO.
    assign fifo_full  = (fifo_cnt == (LOG_FIFO_DEPTH+1)'(DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign s_ar_ready = out_of_reset & ~fifo_full;
    assign push       = s_ar_valid & s_ar_ready;

    assign beat_addr     = act_addr + (ADDR_BITS'(beat_cnt) << BEAT_SHIFT);
    assign beat_in_range = (beat_addr >= bar) && (beat_addr <= limit);
    assign beat_is_last  = (beat_cnt == act_len);
    assign s_r_id        = act_id;

    assign outstandingCnt = (LOG_FIFO_DEPTH+2)'(fifo_cnt)
                          + (LOG_FIFO_DEPTH+2)'(state != ST_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!resetN) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode and R-channel outputs, all derived from registered state.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        s_r_valid = 1'b0;
        s_r_last  = 1'b0;
        s_r_data  = '0;
        s_r_resp  = 2'b00;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = (latency != '0) ? ST_WAIT : ST_BURST;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == LATENCY_WIDTH'(1)) state_nxt = ST_BURST;
            end
            ST_BURST: begin
                s_r_valid = 1'b1;
                s_r_last  = beat_is_last;
                if (beat_in_range) s_r_data = DATA_WIDTH'(beat_addr);
                else               s_r_resp = 2'b10;
                if (s_r_ready && beat_is_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FIFO pointers and occupancy; out_of_reset holds ready low during reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            out_of_reset <= 1'b0;
        end else begin
            out_of_reset <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= s_ar_addr;
            fifo_len[wr_ptr]  <= s_ar_len;
            fifo_id[wr_ptr]   <= s_ar_id;
        end
    end

    // Active burst registers: loaded at pop, latency countdown, beat advance.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            act_addr <= '0;
            act_len  <= '0;
            act_id   <= '0;
            beat_cnt <= '0;
            wait_cnt <= '0;
        end else if (pop) begin
            act_addr <= fifo_addr[rd_ptr];
            act_len  <= fifo_len[rd_ptr];
            act_id   <= fifo_id[rd_ptr];
            beat_cnt <= '0;
            wait_cnt <= latency;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 1'b1;
        end else if (state == ST_BURST && s_r_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: single burst timing, backpressure
// hold, FIFO full, range error, address wrap and reset mid-burst.
module tb_axi_read_responder;

    logic        clk = 1'b0;
    logic        resetN;
    logic        s_ar_valid;
    logic        s_ar_ready;
    logic [63:0] s_ar_addr;
    logic [7:0]  s_ar_len;
    logic [7:0]  s_ar_id;
    logic        s_r_valid;
    logic        s_r_ready;
    logic [7:0]  s_r_id;
    logic [63:0] s_r_data;
    logic [1:0]  s_r_resp;
    logic        s_r_last;
    logic [63:0] bar;
    logic [63:0] limit;
    logic [7:0]  latency;
    logic [3:0]  outstandingCnt;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int peak    = 0;

    axi_read_responder dut (
        .clk(clk), .resetN(resetN),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr),
        .s_ar_len(s_ar_len), .s_ar_id(s_ar_id),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_id(s_r_id),
        .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .bar(bar), .limit(limit), .latency(latency),
        .outstandingCnt(outstandingCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (int'(outstandingCnt) > peak) peak = int'(outstandingCnt);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one AR and holds it until accepted; hs is the cycle whose
    // closing edge performs the handshake.
    task automatic send_ar(input logic [63:0] a, input logic [7:0] l,
                           input logic [7:0] id, output int hs);
        hs = -1;
        @(negedge clk);
        s_ar_valid = 1'b1;
        s_ar_addr  = a;
        s_ar_len   = l;
        s_ar_id    = id;
        for (int k = 0; k < 200; k++) begin
            if (s_ar_ready) begin
                hs = cyc;
                break;
            end
            @(negedge clk);
        end
        chk("ar_accepted", 64'(hs >= 0), 64'd1);
        @(posedge clk);
        #1;
        s_ar_valid = 1'b0;
    endtask

    // Collects one burst, checking every accepted beat against the address
    // model; with bp set, ready follows 1,0,0,1,0,0... and held beats must
    // stay unchanged.
    task automatic recv_burst(input logic [63:0] a0, input int len, input logic [7:0] id,
                              input bit bp, output int first_v, output int last_acc);
        int          beat = 0;
        int          pat  = 0;
        bit          hold = 0;
        logic [63:0] sv_data, ea, ed;
        logic [1:0]  sv_resp, er;
        logic        sv_last;
        first_v  = -1;
        last_acc = -1;
        sv_data  = '0;
        sv_resp  = '0;
        sv_last  = 1'b0;
        for (int k = 0; k < 400 && beat <= len; k++) begin
            @(negedge clk);
            s_r_ready = bp ? (pat % 3 == 0) : 1'b1;
            pat++;
            if (hold) begin
                chk("hold_valid", 64'(s_r_valid), 64'd1);
                chk("hold_data", s_r_data, sv_data);
                chk("hold_resp", 64'(s_r_resp), 64'(sv_resp));
                chk("hold_last", 64'(s_r_last), 64'(sv_last));
            end
            hold = 0;
            if (s_r_valid) begin
                if (first_v < 0) first_v = cyc;
                if (s_r_ready) begin
                    ea = a0 + 64'(beat) * 64'd8;
                    if (ea >= bar && ea <= limit) begin ed = ea;  er = 2'b00; end
                    else                          begin ed = '0;  er = 2'b10; end
                    chk("r_data", s_r_data, ed);
                    chk("r_resp", 64'(s_r_resp), 64'(er));
                    chk("r_id", 64'(s_r_id), 64'(id));
                    chk("r_last", 64'(s_r_last), 64'(beat == len));
                    if (beat == len) last_acc = cyc;
                    beat++;
                end else begin
                    hold    = 1;
                    sv_data = s_r_data;
                    sv_resp = s_r_resp;
                    sv_last = s_r_last;
                end
            end
        end
        chk("r_beats", 64'(beat), 64'(len + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, fv, la, dummy, hs5, acc;
        bit hit;
        int hs [6];

        resetN     = 1'b0;
        s_ar_valid = 1'b0;
        s_ar_addr  = '0;
        s_ar_len   = '0;
        s_ar_id    = '0;
        s_r_ready  = 1'b0;
        bar        = '0;
        limit      = '1;
        latency    = 8'd3;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ar_ready", 64'(s_ar_ready), 64'd0);
        chk("rst_r_valid", 64'(s_r_valid), 64'd0);
        chk("rst_r_last", 64'(s_r_last), 64'd0);
        chk("rst_r_data", s_r_data, 64'd0);
        chk("rst_r_resp", 64'(s_r_resp), 64'd0);
        chk("rst_r_id", 64'(s_r_id), 64'd0);
        chk("rst_outstanding", 64'(outstandingCnt), 64'd0);
        resetN = 1'b1;
        @(negedge clk);
        chk("ar_ready_after_rst", 64'(s_ar_ready), 64'd1);

        // Single burst, latency 3; a latency change after the pop is ignored
        send_ar(64'h1000, 8'd3, 8'd5, t0);
        fork
            begin repeat (2) @(negedge clk); latency = 8'd10; end
            recv_burst(64'h1000, 3, 8'd5, 1'b0, fv, la);
        join
        chk("single_first_cycle", 64'(fv - t0), 64'd5);
        chk("single_last_cycle", 64'(la - t0), 64'd8);
        @(negedge clk);
        chk("single_idle_valid", 64'(s_r_valid), 64'd0);
        chk("single_idle_outst", 64'(outstandingCnt), 64'd0);

        // Backpressure, latency 0: valid at n+2, beat k accepted at n+4+3k
        latency = 8'd0;
        send_ar(64'h4000, 8'd5, 8'h33, t0);
        recv_burst(64'h4000, 5, 8'h33, 1'b1, fv, la);
        chk("bp_first_valid", 64'(fv - t0), 64'd2);
        chk("bp_last_accept", 64'(la - t0), 64'd19);
        @(negedge clk);
        chk("bp_bubble_valid", 64'(s_r_valid), 64'd0);
        chk("bp_bubble_outst", 64'(outstandingCnt), 64'd0);

        // Range error: 0x110 OKAY, 0x118 and 0x120 SLVERR
        latency = 8'd2;
        bar     = 64'h100;
        limit   = 64'h117;
        send_ar(64'h110, 8'd2, 8'h07, t0);
        recv_burst(64'h110, 2, 8'h07, 1'b0, fv, la);
        chk("range_first_cycle", 64'(fv - t0), 64'd4);

        // Address wrap
        bar   = '0;
        limit = '1;
        send_ar(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 8'hA5, t0);
        recv_burst(64'hFFFF_FFFF_FFFF_FFF8, 1, 8'hA5, 1'b0, fv, la);

        // FIFO full: 5 accepted back-to-back, sixth waits for the next pop
        latency = 8'd20;
        peak    = 0;
        fork
            begin
                for (int i = 0; i < 5; i++)
                    send_ar(64'h2000 + 64'(i) * 64'h100, 8'd0, 8'(8'h10 + i), hs[i]);
                @(negedge clk);
                chk("full_ar_ready", 64'(s_ar_ready), 64'd0);
                chk("full_outstanding", 64'(outstandingCnt), 64'd5);
                chk("full_back_to_back", 64'(hs[4] - hs[0]), 64'd4);
                send_ar(64'h2500, 8'd0, 8'h15, hs5);
                chk("full_sixth_accept", 64'(hs5 - hs[0]), 64'd24);
            end
            begin
                for (int i = 0; i < 6; i++)
                    recv_burst(64'h2000 + 64'(i) * 64'h100, 0, 8'(8'h10 + i), 1'b0, fv, la);
            end
        join
        chk("full_peak", 64'(peak), 64'd5);

        // Reset during beat 2 of a len=7 burst with two more queued
        latency = 8'd1;
        send_ar(64'h8000, 8'd7, 8'h09, dummy);
        send_ar(64'h8800, 8'd1, 8'h0A, dummy);
        send_ar(64'h8900, 8'd1, 8'h0B, dummy);
        acc = 0;
        hit = 0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            s_r_ready = 1'b1;
            if (s_r_valid) begin
                if (acc == 2) begin
                    chk("mid_beat2_data", s_r_data, 64'h8010);
                    chk("mid_outstanding", 64'(outstandingCnt), 64'd3);
                    resetN = 1'b0;
                    hit    = 1;
                end else begin
                    acc++;
                end
            end
        end
        chk("mid_reached", 64'(hit), 64'd1);
        @(negedge clk);
        chk("mid_rst_valid", 64'(s_r_valid), 64'd0);
        chk("mid_rst_outst", 64'(outstandingCnt), 64'd0);
        chk("mid_rst_ar_ready", 64'(s_ar_ready), 64'd0);
        resetN = 1'b1;
        @(negedge clk);
        chk("mid_ar_ready_after", 64'(s_ar_ready), 64'd1);
        send_ar(64'h9000, 8'd1, 8'h44, t0);
        recv_burst(64'h9000, 1, 8'h44, 1'b0, fv, la);
        chk("post_rst_first_cycle", 64'(fv - t0), 64'd3);
        @(negedge clk);
        chk("post_rst_outst", 64'(outstandingCnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
